i2c_slave_rx: RTL and testbench
===============================

Name: i2c_slave_rx

Overview:
- Write-only I2C target (slave) receiver. It is the far end of the team's I2C master transmitter FSM.
- Oversamples the open-drain SCL/SDA lines on the system clock and detects START and STOP conditions.
- Matches a 7-bit target address, drives ACK/NACK on SDA, and delivers received data bytes to local logic over a valid/ready handshake.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit target address this block responds to.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (minimum 2).

Ports:
- clk  input  1  system clock, at least 8x SCL frequency.
- rst_n  input  1  reset, asynchronous, active-low.
- scl_in  input  1  raw SCL line level.
- sda_in  input  1  raw SDA line level.
- sda_oe  output  1  1 = pull SDA low (ACK); 0 = release. Pad forces 0 when asserted.
- rx_data  output  8  last received data byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
- busy  output  1  high from START until STOP or IGNORE entry.
- addr_match  output  1  high while addressed, i.e. in DATA or DATA_ACK.
- stop_det  output  1  one-cycle pulse on a STOP condition.
- overrun  output  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, busy=0, addr_match=0, stop_det=0, overrun=0, state=IDLE, bit_cnt=0.
- Input path: SYNC_STAGES flops per line, plus one history flop. Edge and condition detection therefore lags the pins by SYNC_STAGES+1 clk.
- Conditions are evaluated on synced signals:
  - scl_rise / scl_fall: SCL transition.
  - START: SDA 1->0 while SCL high in both current and previous sample.
  - STOP: SDA 0->1 under the same SCL rule.
- Data bits are sampled MSB first on scl_rise into an 8-bit shift register. bit_cnt counts 0..7.
- START from any state (including repeated START): go to ADDR, bit_cnt=0, busy=1, sda_oe=0.
- STOP from any state: go to IDLE, sda_oe=0, busy=0, pulse stop_det. STOP is pulsed even when not addressed.
- States:
  - IDLE: wait for START.
  - ADDR: 8 rising edges. On the 8th: if shift[7:1]==SLAVE_ADDR and R/W bit==0, go to ADDR_ACK; otherwise go to IGNORE. A read request to our own address is NACKed.
  - ADDR_ACK: on the next scl_fall, set sda_oe=1. Count the 9th scl_rise. On the following scl_fall, release sda_oe in the same cycle and go to DATA, bit_cnt=0.
  - DATA: 8 rising edges, addr_match=1. On the 8th:
    - If rx_valid==0, or rx_valid & rx_ready in the same cycle: load rx_data, set rx_valid=1, go to DATA_ACK.
    - Otherwise: pulse overrun, drop the byte, go to IGNORE. sda_oe stays 0, which gives a NACK.
  - DATA_ACK: same ACK timing as ADDR_ACK, then return to DATA for the next byte.
  - IGNORE: sda_oe=0, busy=0. Wait for START or STOP.
- Handshake: rx_valid clears on the clk edge where rx_valid & rx_ready, unless a new byte loads on that same edge, in which case rx_valid stays 1.
- Priority within one cycle: START/STOP override scl edges. STOP overrides START, which cannot coincide on a legal bus.
- sda_oe changes only on a detected scl_fall, or on START/STOP/reset. It is never changed while SCL is high.
- Reset mid-operation: all outputs take their reset values asynchronously. sda_oe deasserts immediately, even mid-ACK.

Optional Feature:
- Macro: I2C_SLAVE_GEN_CALL_EN.
- Defined: address byte 8'h00 (general call, write) is also ACKed and proceeds to DATA like a match. Output port gen_call (1 bit) is high while addressed via general call and clears on START/STOP.
- Undefined: 8'h00 is treated as a non-matching address (goes to IGNORE) and the gen_call port does not exist.

Test Plan:
- START, address 0xA0 (0x50+W), data 0xA5, STOP, rx_ready=1 -> sda_oe=1 during both 9th clocks, rx_data=0xA5, rx_valid one-cycle pulse, stop_det pulse, busy 0 after STOP.
- START, address 0xA2 (0x51+W), data 0x3C -> sda_oe never asserted, rx_valid stays 0, state IGNORE until STOP; same result for 0xA1 (own address, read).
- rx_ready=0, write 0x11 then 0x22 -> first byte ACKed with rx_valid=1 and rx_data=0x11; second byte NACKed (sda_oe=0 on 9th clock), overrun pulse, rx_data stays 0x11.
- Repeated START after 4 address bits, then full 0xA0 + 0x7E -> address restarts cleanly; 0x7E received and ACKed.
- rst_n low while sda_oe=1 in ADDR_ACK -> sda_oe=0 asynchronously; after release, the block ignores the bus until the next START.
- With I2C_SLAVE_GEN_CALL_EN: address 0x00 + data 0x06 -> ACKed, gen_call=1, rx_data=0x06. Without the macro: NACKed, no rx_valid.

Source files
------------

// File: rtl/i2c_slave_rx.sv
// -----------------------------------------------------------------------------
// i2c_slave_rx
//   Write-only I2C target receiver. SCL/SDA are oversampled on clk; START and
//   STOP are detected on the synchronised lines. A write to SLAVE_ADDR is
//   ACKed, and every following data byte is handed to local logic over a
//   valid/ready handshake. A byte that arrives while the previous one is still
//   unconsumed is dropped and NACKed, and the rest of the transfer is ignored.
//
//   Optional feature (macro I2C_SLAVE_GEN_CALL_EN): the general-call address
//   byte 8'h00 is ACKed like a match, and the extra gen_call output is high
//   while addressed that way.
//
// Parameters
//   SLAVE_ADDR   7-bit target address
//   SYNC_STAGES  synchroniser depth on scl_in/sda_in (>= 2)
//
// Ports
//   clk, rst_n   system clock (>= 8x SCL), async active-low reset
//   scl_in       raw SCL level
//   sda_in       raw SDA level
//   sda_oe       1 = pull SDA low (ACK)
//   rx_data      last received data byte
//   rx_valid     rx_data holds an unconsumed byte
//   rx_ready     consumer takes rx_data on rx_valid & rx_ready
//   busy         START seen, no STOP and not ignoring yet
//   addr_match   addressed (DATA / DATA_ACK)
//   stop_det     one-cycle pulse on STOP
//   overrun      one-cycle pulse when a byte is dropped
//   gen_call     (I2C_SLAVE_GEN_CALL_EN only) addressed via general call
// -----------------------------------------------------------------------------
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       addr_match,
    output logic       stop_det,
    output logic       overrun
`ifdef I2C_SLAVE_GEN_CALL_EN
    ,
    output logic       gen_call
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers plus one history flop per line.
    // Reset to 1 so an idle (pulled-up) bus shows no edges after reset.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_c, stop_c;

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise =  scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s &  scl_prev_q;
    // SCL must be high in both samples so an SDA change near an SCL edge
    // is not mistaken for a bus condition.
    assign start_c  = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

    // ------------------------------------------------------------------
    // Shift register next value and address decode
    // ------------------------------------------------------------------
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic       own_match;
    logic       gc_match;
    logic       addr_ok;

    assign shift_d   = {shift_q[6:0], sda_s};
    assign own_match = (shift_d == {SLAVE_ADDR, 1'b0});
`ifdef I2C_SLAVE_GEN_CALL_EN
    assign gc_match  = (shift_d == 8'h00);
`else
    assign gc_match  = 1'b0;
`endif
    assign addr_ok   = own_match | gc_match;

    // ------------------------------------------------------------------
    // Protocol FSM with registered outputs
    // ------------------------------------------------------------------
    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic       ninth_q;      // 9th SCL rise seen during an ACK slot
    logic       sda_oe_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       busy_q;
    logic       addr_match_q;
    logic       stop_det_q;
    logic       overrun_q;
    logic       gen_call_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            ninth_q      <= 1'b0;
            shift_q      <= 8'h00;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            addr_match_q <= 1'b0;
            stop_det_q   <= 1'b0;
            overrun_q    <= 1'b0;
            gen_call_q   <= 1'b0;
        end else begin
            stop_det_q <= 1'b0;
            overrun_q  <= 1'b0;

            // Consumption; a byte loaded later in this block wins.
            if (rx_valid_q && rx_ready)
                rx_valid_q <= 1'b0;

            if (stop_c) begin
                state_q      <= IDLE;
                sda_oe_q     <= 1'b0;
                busy_q       <= 1'b0;
                addr_match_q <= 1'b0;
                stop_det_q   <= 1'b1;
                ninth_q      <= 1'b0;
                gen_call_q   <= 1'b0;
            end else if (start_c) begin
                state_q      <= ADDR;
                bit_cnt_q    <= 3'd0;
                busy_q       <= 1'b1;
                sda_oe_q     <= 1'b0;
                addr_match_q <= 1'b0;
                ninth_q      <= 1'b0;
                gen_call_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;

                    ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (addr_ok) begin
                                    state_q    <= ADDR_ACK;
                                    gen_call_q <= gc_match;
                                end else begin
                                    state_q <= IGNORE;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                    end

                    // Drive ACK from the fall after bit 8 until the fall
                    // after the 9th rise, so SDA only moves while SCL is low.
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_rise && sda_oe_q) begin
                            ninth_q <= 1'b1;
                        end else if (scl_fall) begin
                            if (ninth_q) begin
                                sda_oe_q     <= 1'b0;
                                ninth_q      <= 1'b0;
                                state_q      <= DATA;
                                bit_cnt_q    <= 3'd0;
                                addr_match_q <= 1'b1;
                            end else begin
                                sda_oe_q <= 1'b1;
                            end
                        end
                    end

                    DATA: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (!rx_valid_q || rx_ready) begin
                                    rx_data_q  <= shift_d;
                                    rx_valid_q <= 1'b1;
                                    state_q    <= DATA_ACK;
                                end else begin
                                    // Byte dropped; leaving sda_oe low NACKs it.
                                    overrun_q    <= 1'b1;
                                    state_q      <= IGNORE;
                                    busy_q       <= 1'b0;
                                    addr_match_q <= 1'b0;
                                end
                            end
                        end
                    end

                    IGNORE: ;

                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sda_oe     = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = busy_q;
    assign addr_match = addr_match_q;
    assign stop_det   = stop_det_q;
    assign overrun    = overrun_q;
`ifdef I2C_SLAVE_GEN_CALL_EN
    assign gen_call   = gen_call_q;
`else
    logic unused_gc;
    assign unused_gc  = gen_call_q;
`endif

endmodule

// File: tb/tb_i2c_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_rx
//   Bench for i2c_slave_rx. A behavioural I2C master drives the bus through an
//   open-drain model; bytes the target should accept are pushed to a queue and
//   compared when the DUT hands them out on rx_valid & rx_ready.
// -----------------------------------------------------------------------------
module tb_i2c_slave_rx;

    localparam int Q = 10;   // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_drv, sda_drv;
    logic       rx_ready;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, busy, addr_match, stop_det, overrun;
`ifdef I2C_SLAVE_GEN_CALL_EN
    logic       gen_call;
`endif
    logic       sda_line;

    assign sda_line = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_in     (scl_drv),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .addr_match (addr_match),
        .stop_det   (stop_det),
        .overrun    (overrun)
`ifdef I2C_SLAVE_GEN_CALL_EN
        ,
        .gen_call   (gen_call)
`endif
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         valid_cycles = 0;
    int         stop_cnt     = 0;
    int         ovr_cnt      = 0;
    logic       oe_seen      = 1'b0;
    logic       scl_prev     = 1'b1;
    logic       oe_prev      = 1'b0;

    // Monitor: scoreboard pops, event counters, SDA-stable-while-SCL-high.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid) valid_cycles++;
            if (stop_det) stop_cnt++;
            if (overrun)  ovr_cnt++;
            if (sda_oe)   oe_seen = 1'b1;
            if (rx_valid && rx_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rx_unexpected: got byte %h, none expected", rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        n_fail++;
                        $display("FAIL rx_byte: got %h want %h", rx_data, e);
                    end
                end
            end
            if (scl_drv && scl_prev) begin
                n_checks++;
                if (sda_oe !== oe_prev) begin
                    n_fail++;
                    $display("FAIL sda_oe_scl_high: sda_oe %b->%b while SCL high", oe_prev, sda_oe);
                end
            end
        end
        scl_prev = scl_drv;
        oe_prev  = sda_oe;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        valid_cycles = 0;
        stop_cnt     = 0;
        ovr_cnt      = 0;
        oe_seen      = 1'b0;
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;    tick(Q);
        scl_drv = 1'b1; tick(2*Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    // 9th clock: master releases SDA and samples the target's ACK.
    task automatic ack_bit(output logic ack);
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        ack = sda_oe;   tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_bit(ack);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1; rx_ready = 1'b1;
        tick(5);
        n_checks++; if (sda_oe !== 1'b0)     begin n_fail++; $display("FAIL rst_sda_oe: got %b want 0", sda_oe); end
        n_checks++; if (rx_data !== 8'h00)   begin n_fail++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL rst_addr_match: got %b want 0", addr_match); end
        n_checks++; if (stop_det !== 1'b0)   begin n_fail++; $display("FAIL rst_stop_det: got %b want 0", stop_det); end
        n_checks++; if (overrun !== 1'b0)    begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_write();
        logic ack;
        clear_counts();
        rx_ready = 1'b1;
        bus_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b want 1", busy); end
        send_byte(8'hA0, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_addr_ack: got %b want 1", ack); end
        n_checks++; if (addr_match !== 1'b1) begin n_fail++; $display("FAIL wr_addr_match: got %b want 1", addr_match); end
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_data_ack: got %b want 1", ack); end
        bus_stop();
        n_checks++; if (stop_cnt != 1)      begin n_fail++; $display("FAIL wr_stop_det: got %0d pulses want 1", stop_cnt); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL wr_busy_after: got %b want 0", busy); end
        n_checks++; if (valid_cycles != 1)  begin n_fail++; $display("FAIL wr_valid_pulse: got %0d cycles want 1", valid_cycles); end
        n_checks++; if (rx_data !== 8'hA5)  begin n_fail++; $display("FAIL wr_rx_data: got %h want a5", rx_data); end
        n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL wr_match_after: got %b want 0", addr_match); end
    endtask

    task automatic test_nomatch(input logic [7:0] addr);
        logic ack;
        clear_counts();
        bus_start();
        send_byte(addr, ack);
        n_checks++; if (ack !== 1'b0)  begin n_fail++; $display("FAIL nm_addr_ack %h: got %b want 0", addr, ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nm_busy %h: got %b want 0", addr, busy); end
        send_byte(8'h3C, ack);
        n_checks++; if (ack !== 1'b0)  begin n_fail++; $display("FAIL nm_data_ack %h: got %b want 0", addr, ack); end
        n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL nm_addr_match %h: got %b want 0", addr, addr_match); end
        bus_stop();
        n_checks++; if (oe_seen !== 1'b0)  begin n_fail++; $display("FAIL nm_oe_seen %h: got %b want 0", addr, oe_seen); end
        n_checks++; if (valid_cycles != 0) begin n_fail++; $display("FAIL nm_valid %h: got %0d want 0", addr, valid_cycles); end
        n_checks++; if (stop_cnt != 1)     begin n_fail++; $display("FAIL nm_stop_det %h: got %0d want 1", addr, stop_cnt); end
    endtask

    task automatic test_overrun();
        logic ack;
        clear_counts();
        rx_ready = 1'b0;
        bus_start();
        send_byte(8'hA0, ack);
        exp_q.push_back(8'h11);
        send_byte(8'h11, ack);
        n_checks++; if (ack !== 1'b1)      begin n_fail++; $display("FAIL ov_first_ack: got %b want 1", ack); end
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ov_rx_valid: got %b want 1", rx_valid); end
        n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ov_rx_data1: got %h want 11", rx_data); end
        send_byte(8'h22, ack);
        n_checks++; if (ack !== 1'b0)      begin n_fail++; $display("FAIL ov_second_ack: got %b want 0", ack); end
        n_checks++; if (ovr_cnt != 1)      begin n_fail++; $display("FAIL ov_pulse: got %0d want 1", ovr_cnt); end
        n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ov_rx_data2: got %h want 11", rx_data); end
        bus_stop();
        rx_ready = 1'b1;
        tick(3);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ov_consumed: got %b want 0", rx_valid); end
    endtask

    task automatic test_repeated_start();
        logic ack;
        clear_counts();
        rx_ready = 1'b1;
        bus_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bus_start();
        send_byte(8'hA0, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rs_addr_ack: got %b want 1", ack); end
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rs_data_ack: got %b want 1", ack); end
        bus_stop();
        n_checks++; if (valid_cycles != 1) begin n_fail++; $display("FAIL rs_valid: got %0d want 1", valid_cycles); end
    endtask

    task automatic test_reset_mid_ack();
        logic ack;
        logic [7:0] a;
        clear_counts();
        a = 8'hA0;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(a[i]);
        sda_drv = 1'b1;
        tick(Q);
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rm_ack_driven: got %b want 1", sda_oe); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rm_async_oe: got %b want 0", sda_oe); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rm_async_busy: got %b want 0", busy); end
        tick(3);
        rst_n = 1'b1;
        tick(2);
        clear_counts();
        scl_drv = 1'b1; tick(2*Q);
        scl_drv = 1'b0; tick(Q);
        send_byte(8'h55, ack);
        n_checks++; if (ack !== 1'b0)      begin n_fail++; $display("FAIL rm_ignored_ack: got %b want 0", ack); end
        n_checks++; if (valid_cycles != 0) begin n_fail++; $display("FAIL rm_ignored_valid: got %0d want 0", valid_cycles); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rm_ignored_busy: got %b want 0", busy); end
        bus_stop();
        bus_start();
        send_byte(8'hA0, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rm_recover_ack: got %b want 1", ack); end
        exp_q.push_back(8'h99);
        send_byte(8'h99, ack);
        bus_stop();
    endtask

    task automatic test_gen_call();
        logic ack;
        clear_counts();
        rx_ready = 1'b1;
        bus_start();
        send_byte(8'h00, ack);
`ifdef I2C_SLAVE_GEN_CALL_EN
        n_checks++; if (ack !== 1'b1)      begin n_fail++; $display("FAIL gc_addr_ack: got %b want 1", ack); end
        n_checks++; if (gen_call !== 1'b1) begin n_fail++; $display("FAIL gc_flag: got %b want 1", gen_call); end
        exp_q.push_back(8'h06);
        send_byte(8'h06, ack);
        n_checks++; if (ack !== 1'b1)      begin n_fail++; $display("FAIL gc_data_ack: got %b want 1", ack); end
        n_checks++; if (rx_data !== 8'h06) begin n_fail++; $display("FAIL gc_rx_data: got %h want 06", rx_data); end
        bus_stop();
        n_checks++; if (gen_call !== 1'b0) begin n_fail++; $display("FAIL gc_flag_clear: got %b want 0", gen_call); end
`else
        n_checks++; if (ack !== 1'b0)      begin n_fail++; $display("FAIL gc_addr_nack: got %b want 0", ack); end
        send_byte(8'h06, ack);
        bus_stop();
        n_checks++; if (valid_cycles != 0) begin n_fail++; $display("FAIL gc_no_valid: got %0d want 0", valid_cycles); end
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_nomatch(8'hA2);
        test_nomatch(8'hA1);
        test_overrun();
        test_repeated_start();
        test_reset_mid_ack();
        test_gen_call();
        tick(5);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d bytes outstanding want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
